// File: rtl/panda_divider.sv
// Iterative restoring radix-2 divider with signed/unsigned quotient and remainder.
// Valid/ready handshake on both sides; divide-by-zero and signed overflow are resolved in one edge.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request, ready_o high
// CALC  | one quotient bit per cycle, MSB first, Width cycles
// FIX   | apply quotient/remainder signs, select result by op
// DONE  | result presented, valid_o high until the consumer takes it
module panda_divider #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [Width-1:0] dividend_i,
    input  logic [Width-1:0] divisor_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    localparam logic [Width-1:0] AllOnes  = '1;
    localparam logic [Width-1:0] MinVal   = {1'b1, {(Width-1){1'b0}}};
    localparam logic [Width-1:0] LastIter = Width'(Width - 1);

    state_e           state_q, state_d;
    logic [Width-1:0] cnt_q;
    logic [Width-1:0] rem_q;
    logic [Width-1:0] quo_q;
    logic [Width-1:0] div_q;
    logic [Width-1:0] result_q;
    logic [1:0]       op_q;
    logic             q_neg_q, r_neg_q;

    logic             accept, is_signed, sign_a, sign_b, div_zero, overflow;
    logic [Width-1:0] abs_a, abs_b;
    logic [Width:0]   shifted;
    logic [Width:0]   trial;
    logic             qbit;
    logic [Width-1:0] quo_fix, rem_fix;

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = valid_o ? result_q : '0;

    assign accept    = valid_i & ready_o & ~flush_i;
    assign is_signed = ~op_i[0];
    assign sign_a    = is_signed & dividend_i[Width-1];
    assign sign_b    = is_signed & divisor_i[Width-1];
    assign abs_a     = sign_a ? -dividend_i : dividend_i;
    assign abs_b     = sign_b ? -divisor_i : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign overflow  = is_signed & (dividend_i == MinVal) & (divisor_i == AllOnes);

    // quo_q doubles as the dividend shift register: its MSB is the next dividend bit.
    // When the shifted-out bit is set the partial remainder exceeds any divisor,
    // so the subtraction always succeeds and only Width+1 bits are needed.
    assign shifted = {rem_q, quo_q[Width-1]};
    assign trial   = {1'b0, shifted[Width-1:0]} - {1'b0, div_q};
    assign qbit    = shifted[Width] | ~trial[Width];

    assign quo_fix = (q_neg_q & ~op_q[0]) ? -quo_q : quo_q;
    assign rem_fix = (r_neg_q & ~op_q[0]) ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (div_zero | overflow) ? DONE : CALC;
            CALC: if (cnt_q == LastIter) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            result_q <= '0;
            op_q     <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q    <= op_i;
                    cnt_q   <= '0;
                    rem_q   <= '0;
                    quo_q   <= abs_a;
                    div_q   <= abs_b;
                    q_neg_q <= sign_a ^ sign_b;
                    r_neg_q <= sign_a;
                    if (div_zero)      result_q <= op_i[1] ? dividend_i : AllOnes;
                    else if (overflow) result_q <= op_i[1] ? '0 : MinVal;
                end
                CALC: begin
                    rem_q <= qbit ? trial[Width-1:0] : shifted[Width-1:0];
                    quo_q <= {quo_q[Width-2:0], qbit};
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: result_q <= op_q[1] ? rem_fix : quo_fix;
                default: ;
            endcase
        end
    end

endmodule
